// File: rtl/filter_kernel_fetcher.sv
// Filter kernel fetcher: walks a run of 3x3x3 kernels in the filter memory, issues one
// byte read per clock, absorbs the read latency and presents each packed kernel to the
// conv engine over a valid/ready handshake.
module filter_kernel_fetcher #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned KERNEL_SIZE = 27,
  parameter int unsigned NUM_KERNELS = 8,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_start,
  input  logic [2:0]                    i_first_kernel,
  input  logic [3:0]                    i_num_kernels,
  output logic [ADDR_W-1:0]             o_mem_addr,
  output logic                          o_mem_en,
  input  logic [DATA_W-1:0]             i_mem_data,
  output logic [DATA_W*KERNEL_SIZE-1:0] o_kernel_data,
  output logic                          o_kernel_valid,
  input  logic                          i_kernel_ready,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_err
);

  localparam int unsigned IdxW = $clog2(KERNEL_SIZE);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StHold} state_e;

  state_e                    r_state, w_state_nxt;
  logic [3:0]                r_k, w_k_nxt;
  logic [3:0]                r_remain, w_remain_nxt;
  logic [IdxW-1:0]           r_idx, w_idx_nxt;
  logic [ADDR_W-1:0]         r_mem_addr, w_addr_nxt;
  logic                      r_mem_en, w_en_nxt;
  logic                      r_kernel_valid, w_valid_nxt;
  logic                      r_done, w_done_nxt;
  logic                      r_err, w_err_nxt;
  logic [DATA_W*KERNEL_SIZE-1:0] r_kernel_data;

  // In-flight reads: {valid, slot} travels alongside the memory's latency.
  logic [RD_LAT-1:0]         r_pipe_vld;
  logic [IdxW-1:0]           r_pipe_idx [RD_LAT];

  logic [4:0]                w_end_kernel;
  logic                      w_start_ok;
  logic                      w_pipe_busy;

  function automatic logic [ADDR_W-1:0] kernel_base(input logic [3:0] k);
    return ADDR_W'(BASE_ADDR) + ADDR_W'(k) * ADDR_W'(KERNEL_SIZE);
  endfunction

  assign w_end_kernel = {2'b00, i_first_kernel} + {1'b0, i_num_kernels};
  assign w_start_ok   = (i_num_kernels != 4'd0) && (w_end_kernel <= 5'(NUM_KERNELS));
  assign w_pipe_busy  = |r_pipe_vld;

  // Next-state and next-output logic for the fetch sequencer.
  always_comb begin
    w_state_nxt  = r_state;
    w_k_nxt      = r_k;
    w_remain_nxt = r_remain;
    w_idx_nxt    = r_idx;
    w_addr_nxt   = r_mem_addr;
    w_en_nxt     = 1'b0;
    w_valid_nxt  = r_kernel_valid;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          if (w_start_ok) begin
            w_k_nxt      = {1'b0, i_first_kernel};
            w_remain_nxt = i_num_kernels;
            w_idx_nxt    = '0;
            w_addr_nxt   = kernel_base({1'b0, i_first_kernel});
            w_en_nxt     = 1'b1;
            w_state_nxt  = StFetch;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      StFetch: begin
        if (r_idx == IdxW'(KERNEL_SIZE - 1)) begin
          w_state_nxt = StDrain;
        end else begin
          w_idx_nxt  = r_idx + 1'b1;
          w_addr_nxt = r_mem_addr + 1'b1;
          w_en_nxt   = 1'b1;
        end
      end
      StDrain: begin
        // Wait until every outstanding read has landed in its slot.
        if (!w_pipe_busy) begin
          w_valid_nxt = 1'b1;
          w_state_nxt = StHold;
        end
      end
      StHold: begin
        if (i_kernel_ready) begin
          w_valid_nxt = 1'b0;
          if (r_remain > 4'd1) begin
            w_remain_nxt = r_remain - 1'b1;
            w_k_nxt      = r_k + 1'b1;
            w_idx_nxt    = '0;
            w_addr_nxt   = kernel_base(r_k + 1'b1);
            w_en_nxt     = 1'b1;
            w_state_nxt  = StFetch;
          end else begin
            w_done_nxt  = 1'b1;
            w_state_nxt = StIdle;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state        <= StIdle;
      r_k            <= '0;
      r_remain       <= '0;
      r_idx          <= '0;
      r_mem_addr     <= '0;
      r_mem_en       <= 1'b0;
      r_kernel_valid <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_k            <= w_k_nxt;
      r_remain       <= w_remain_nxt;
      r_idx          <= w_idx_nxt;
      r_mem_addr     <= w_addr_nxt;
      r_mem_en       <= w_en_nxt;
      r_kernel_valid <= w_valid_nxt;
      r_done         <= w_done_nxt;
      r_err          <= w_err_nxt;
    end
  end

  // Read-latency pipeline: tags each issued address with its slot index.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pipe_vld <= '0;
      for (int j = 0; j < RD_LAT; j++) r_pipe_idx[j] <= '0;
    end else begin
      r_pipe_vld[0] <= r_mem_en;
      r_pipe_idx[0] <= r_idx;
      for (int j = 1; j < RD_LAT; j++) begin
        r_pipe_vld[j] <= r_pipe_vld[j-1];
        r_pipe_idx[j] <= r_pipe_idx[j-1];
      end
    end
  end

  // Write returning read data in place into its weight slot.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_kernel_data <= '0;
    end else if (r_pipe_vld[RD_LAT-1]) begin
      r_kernel_data[r_pipe_idx[RD_LAT-1]*DATA_W +: DATA_W] <= i_mem_data;
    end
  end

  assign o_mem_addr     = r_mem_addr;
  assign o_mem_en       = r_mem_en;
  assign o_kernel_data  = r_kernel_data;
  assign o_kernel_valid = r_kernel_valid;
  assign o_busy         = (r_state != StIdle);
  assign o_done         = r_done;
  assign o_err          = r_err;

endmodule

// File: tb/tb_filter_kernel_fetcher.sv
// Directed self-checking bench for filter_kernel_fetcher with a registered 1-cycle memory
// model returning mem[a] = a[7:0].
module tb_filter_kernel_fetcher;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [2:0]   first_kernel;
  logic [3:0]   num_kernels;
  logic [8:0]   mem_addr;
  logic         mem_en;
  logic [7:0]   mem_data;
  logic [215:0] kernel_data;
  logic         kernel_valid;
  logic         kernel_ready;
  logic         busy;
  logic         done;
  logic         err;

  int nchk = 0;
  int nerr = 0;

  filter_kernel_fetcher dut (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .i_start        (start),
    .i_first_kernel (first_kernel),
    .i_num_kernels  (num_kernels),
    .o_mem_addr     (mem_addr),
    .o_mem_en       (mem_en),
    .i_mem_data     (mem_data),
    .o_kernel_data  (kernel_data),
    .o_kernel_valid (kernel_valid),
    .i_kernel_ready (kernel_ready),
    .o_busy         (busy),
    .o_done         (done),
    .o_err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered filter ROM, one cycle of read latency.
  always @(posedge clk) mem_data <= mem_addr[7:0];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [215:0] exp_kernel(input int base);
    logic [215:0] r;
    r = '0;
    for (int i = 0; i < 27; i++) r[i*8 +: 8] = 8'(base + i);
    return r;
  endfunction

  // Pulse start for one edge; returns at the sample point just after that edge.
  task automatic do_start(input int f, input int n);
    first_kernel = 3'(f);
    num_kernels  = 4'(n);
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  // Measures one kernel fetch from the cycle its first address is live until valid rises.
  task automatic observe(input int base, input int poke_at, output int en_cnt,
                         output int addr_bad, output int lat, output int err_cnt,
                         output logic [215:0] data);
    en_cnt = 0; addr_bad = 0; lat = -1; err_cnt = 0; data = '0;
    for (int j = 0; j < 100; j++) begin
      if (mem_en) begin
        if (mem_addr !== 9'(base + en_cnt)) addr_bad++;
        en_cnt++;
      end
      if (err) err_cnt++;
      if (kernel_valid) begin
        lat  = j;
        data = kernel_data;
        break;
      end
      if (j == poke_at) begin
        start = 1'b1; first_kernel = 3'd3; num_kernels = 4'd2;
      end
      tick();
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    nchk++;
    if ({mem_en, mem_addr, kernel_valid, busy, done, err} !== '0 || kernel_data !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: en=%b addr=%0d valid=%b busy=%b done=%b err=%b (want all 0)",
               mem_en, mem_addr, kernel_valid, busy, done, err);
    end
  endtask

  task automatic test_single(input int f, input int poke_at, input string nm);
    int en_cnt, addr_bad, lat, err_cnt;
    logic [215:0] d;
    int base;
    base = f * 27;
    do_start(f, 1);
    nchk++;
    if (busy !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 9'(base)) begin
      nerr++;
      $display("FAIL %s_first_addr: busy=%b en=%b addr=%0d want 1 1 %0d", nm, busy, mem_en,
               mem_addr, base);
    end
    observe(base, poke_at, en_cnt, addr_bad, lat, err_cnt, d);
    nchk++;
    if (lat !== 29) begin nerr++; $display("FAIL %s_latency: got %0d want 29", nm, lat); end
    nchk++;
    if (en_cnt !== 27) begin nerr++; $display("FAIL %s_en_cycles: got %0d want 27", nm, en_cnt); end
    nchk++;
    if (addr_bad !== 0) begin nerr++; $display("FAIL %s_addr_seq: bad=%0d want 0", nm, addr_bad); end
    nchk++;
    if (err_cnt !== 0) begin nerr++; $display("FAIL %s_no_err: got %0d want 0", nm, err_cnt); end
    nchk++;
    if (d !== exp_kernel(base)) begin
      nerr++;
      $display("FAIL %s_data: got %h want %h", nm, d, exp_kernel(base));
    end
    nchk++;
    if (d[215:208] !== 8'(base + 26)) begin
      nerr++;
      $display("FAIL %s_top_slot: got %h want %h", nm, d[215:208], 8'(base + 26));
    end
    kernel_ready = 1'b1;
    tick();
    kernel_ready = 1'b0;
    nchk++;
    if (done !== 1'b1 || kernel_valid !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL %s_accept: done=%b valid=%b busy=%b want 1 0 0", nm, done, kernel_valid, busy);
    end
    tick();
    nchk++;
    if (done !== 1'b0) begin nerr++; $display("FAIL %s_done_pulse: got %b want 0", nm, done); end
  endtask

  // Ready held high through the fetch must not be taken before valid.
  task automatic test_ready_early();
    int en_cnt, addr_bad, lat, err_cnt;
    logic [215:0] d;
    do_start(7, 1);
    kernel_ready = 1'b1;
    observe(189, -1, en_cnt, addr_bad, lat, err_cnt, d);
    nchk++;
    if (lat !== 29 || en_cnt !== 27 || addr_bad !== 0) begin
      nerr++;
      $display("FAIL early_ready_fetch: lat=%0d en=%0d bad=%0d want 29 27 0", lat, en_cnt, addr_bad);
    end
    nchk++;
    if (d !== exp_kernel(189)) begin
      nerr++;
      $display("FAIL early_ready_data: got %h want %h", d, exp_kernel(189));
    end
    tick();
    kernel_ready = 1'b0;
    nchk++;
    if (done !== 1'b1 || kernel_valid !== 1'b0) begin
      nerr++;
      $display("FAIL early_ready_accept: done=%b valid=%b want 1 0", done, kernel_valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int en_cnt, addr_bad, lat, err_cnt, unstable;
    logic [215:0] d;
    do_start(2, 3);
    for (int k = 0; k < 3; k++) begin
      observe(54 + 27 * k, -1, en_cnt, addr_bad, lat, err_cnt, d);
      nchk++;
      if (lat !== 29 || en_cnt !== 27 || addr_bad !== 0) begin
        nerr++;
        $display("FAIL b2b_fetch%0d: lat=%0d en=%0d bad=%0d want 29 27 0", k, lat, en_cnt, addr_bad);
      end
      nchk++;
      if (d !== exp_kernel(54 + 27 * k)) begin
        nerr++;
        $display("FAIL b2b_data%0d: got %h want %h", k, d, exp_kernel(54 + 27 * k));
      end
      unstable = 0;
      for (int h = 0; h < 10; h++) begin
        tick();
        if (kernel_valid !== 1'b1 || kernel_data !== d || mem_en !== 1'b0 || done !== 1'b0)
          unstable++;
      end
      nchk++;
      if (unstable !== 0) begin
        nerr++;
        $display("FAIL b2b_hold%0d: unstable cycles=%0d want 0", k, unstable);
      end
      kernel_ready = 1'b1;
      tick();
      kernel_ready = 1'b0;
      nchk++;
      if (k < 2) begin
        if (done !== 1'b0 || kernel_valid !== 1'b0 || busy !== 1'b1 ||
            mem_addr !== 9'(54 + 27 * (k + 1))) begin
          nerr++;
          $display("FAIL b2b_next%0d: done=%b valid=%b busy=%b addr=%0d want 0 0 1 %0d", k, done,
                   kernel_valid, busy, mem_addr, 54 + 27 * (k + 1));
        end
      end else if (done !== 1'b1 || busy !== 1'b0) begin
        nerr++;
        $display("FAIL b2b_last: done=%b busy=%b want 1 0", done, busy);
      end
    end
    tick();
    nchk++;
    if (done !== 1'b0) begin nerr++; $display("FAIL b2b_single_done: got %b want 0", done); end
  endtask

  task automatic test_reject(input int f, input int n, input string nm);
    do_start(f, n);
    nchk++;
    if (err !== 1'b1 || busy !== 1'b0 || mem_en !== 1'b0) begin
      nerr++;
      $display("FAIL %s_reject: err=%b busy=%b en=%b want 1 0 0", nm, err, busy, mem_en);
    end
    tick();
    nchk++;
    if (err !== 1'b0 || busy !== 1'b0 || mem_en !== 1'b0) begin
      nerr++;
      $display("FAIL %s_after: err=%b busy=%b en=%b want 0 0 0", nm, err, busy, mem_en);
    end
  endtask

  task automatic test_mid_reset();
    do_start(4, 1);
    for (int j = 0; j < 13; j++) tick();
    nchk++;
    if (mem_addr !== 9'd121 || mem_en !== 1'b1) begin
      nerr++;
      $display("FAIL midrst_pre: addr=%0d en=%b want 121 1", mem_addr, mem_en);
    end
    #2;
    reset_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    tick();
    nchk++;
    if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL midrst_quiet: done=%b err=%b busy=%b want 0 0 0", done, err, busy);
    end
    test_single(1, -1, "post_reset");
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; first_kernel = '0; num_kernels = '0; kernel_ready = 1'b0;
    #23;
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    test_reset();
    test_single(0, -1, "single_k0");
    test_ready_early();
    test_back_to_back();
    test_reject(6, 3, "overrun");
    test_reject(0, 0, "zero");
    test_single(0, 5, "busy_start");
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
